// File: rtl/wb_div_pkg.sv
// rtl/wb_div_pkg.sv - shared types and register map for the Wishbone divider initiator
// Contents: sequencer state enum, divider slave register offsets, STATUS/CTRL bit
// positions, and a helper mapping a bus state to the register it targets.
package wb_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DVD  = 3'd1,
    S_WR_DVS  = 3'd2,
    S_WR_CTRL = 3'd3,
    S_RD_STAT = 3'd4,
    S_RD_QUO  = 3'd5,
    S_RD_REM  = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  localparam logic [7:0] OFS_DVD  = 8'h00;
  localparam logic [7:0] OFS_DVS  = 8'h04;
  localparam logic [7:0] OFS_CTRL = 8'h08;
  localparam logic [7:0] OFS_STAT = 8'h0C;
  localparam logic [7:0] OFS_QUO  = 8'h10;
  localparam logic [7:0] OFS_REM  = 8'h14;

  localparam int STAT_DONE_BIT  = 0;
  localparam int CTRL_START_BIT = 0;

  function automatic logic [7:0] state_ofs(input state_t s);
    case (s)
      S_WR_DVD:  state_ofs = OFS_DVD;
      S_WR_DVS:  state_ofs = OFS_DVS;
      S_WR_CTRL: state_ofs = OFS_CTRL;
      S_RD_STAT: state_ofs = OFS_STAT;
      S_RD_QUO:  state_ofs = OFS_QUO;
      S_RD_REM:  state_ofs = OFS_REM;
      default:   state_ofs = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// rtl/wb_single_xfer.sv - one Wishbone classic transfer with a stall timeout
// Ports: clk_i/reset_i (sync, active-high); start_i/we_i/adr_i/dat_i launch a transfer
// when idle; busy_o is high while stb is up; done_o pulses in the ack cycle with
// rdata_o valid; err_o pulses in the last stalled cycle before the abort;
// wbm_* drive the bus (wbm_sel_o is constant all ones).
module wb_single_xfer #(
  parameter int WBW     = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             we_i,
  input  logic [WBW-1:0]   adr_i,
  input  logic [WBW-1:0]   dat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WBW-1:0]   rdata_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WBW/8-1:0] wbm_sel_o,
  output logic [WBW-1:0]   wbm_adr_o,
  output logic [WBW-1:0]   wbm_dat_o,
  input  logic [WBW-1:0]   wbm_dat_i,
  input  logic             wbm_ack_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          last_wait;

  // cnt holds the number of stalled cycles already completed; the transfer is
  // abandoned at the edge that closes the TIMEOUT-th stb-high cycle.
  assign last_wait = (cnt == CW'(TIMEOUT - 1));

  assign busy_o    = wbm_stb_o;
  assign done_o    = wbm_stb_o & wbm_ack_i;
  assign err_o     = wbm_stb_o & ~wbm_ack_i & last_wait;
  assign rdata_o   = wbm_dat_i;
  assign wbm_sel_o = '1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      cnt       <= '0;
    end else if (wbm_stb_o) begin
      if (wbm_ack_i || last_wait) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (start_i) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= we_i;
      wbm_adr_o <= adr_i;
      wbm_dat_o <= dat_i;
      cnt       <= '0;
    end
  end

endmodule

// File: rtl/wb_div_master.sv
// rtl/wb_div_master.sv - request/response front end that runs the divider slave over Wishbone
// Ports: clk_i/reset_i (sync, active-high); req_* valid/ready request stream carrying
// dividend/divisor; rsp_* valid/ready response stream carrying quotient, remainder
// and err (1 = transfer timeout or poll limit); wbm_* Wishbone classic initiator.
module wb_div_master
  import wb_div_pkg::*;
#(
  parameter int             WBW      = 32,
  parameter int             XLEN     = 32,
  parameter logic [WBW-1:0] BASE_ADR = 32'h3000_0000,
  parameter int             TIMEOUT  = 64,
  parameter int             POLL_MAX = 1024
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  req_dividend_i,
  input  logic [XLEN-1:0]  req_divisor_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  rsp_quotient_o,
  output logic [XLEN-1:0]  rsp_remainder_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WBW/8-1:0] wbm_sel_o,
  output logic [WBW-1:0]   wbm_adr_o,
  output logic [WBW-1:0]   wbm_dat_o,
  input  logic [WBW-1:0]   wbm_dat_i,
  input  logic             wbm_ack_i
);

  localparam int             PW         = $clog2(POLL_MAX + 1);
  localparam logic [WBW-1:0] START_WORD = WBW'(1) << CTRL_START_BIT;

  state_t          state;
  state_t          tgt;
  logic            issue;
  logic [PW-1:0]   poll_cnt;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;

  logic            req_fire;
  logic            launch;
  logic            x_we;
  logic [WBW-1:0]  x_adr;
  logic [WBW-1:0]  x_dat;
  logic            x_busy;
  logic            x_done;
  logic            x_err;
  logic [WBW-1:0]  x_rdata;

  assign req_fire = req_valid_i & req_ready_o;

  // The first transfer launches straight off the request handshake and every
  // later one off the registered issue flag, which is set on the previous ack
  // edge; this gives the mandatory single idle cycle between transfers.
  always_comb begin
    tgt    = (state == S_IDLE) ? S_WR_DVD : state;
    launch = ~x_busy & ((req_fire & (req_divisor_i != '0)) | issue);
    x_we   = (tgt == S_WR_DVD) || (tgt == S_WR_DVS) || (tgt == S_WR_CTRL);
    x_adr  = BASE_ADR + WBW'(state_ofs(tgt));
    x_dat  = '0;
    case (tgt)
      S_WR_DVD:  x_dat = (state == S_IDLE) ? WBW'(req_dividend_i) : WBW'(dvd_q);
      S_WR_DVS:  x_dat = WBW'(dvs_q);
      S_WR_CTRL: x_dat = START_WORD;
      default:   x_dat = '0;
    endcase
  end

  wb_single_xfer #(
    .WBW     (WBW),
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (launch),
    .we_i      (x_we),
    .adr_i     (x_adr),
    .dat_i     (x_dat),
    .busy_o    (x_busy),
    .done_o    (x_done),
    .err_o     (x_err),
    .rdata_o   (x_rdata),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= S_IDLE;
      req_ready_o     <= 1'b1;
      rsp_valid_o     <= 1'b0;
      rsp_quotient_o  <= '0;
      rsp_remainder_o <= '0;
      rsp_err_o       <= 1'b0;
      issue           <= 1'b0;
      poll_cnt        <= '0;
      dvd_q           <= '0;
      dvs_q           <= '0;
    end else begin
      issue <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            dvd_q       <= req_dividend_i;
            dvs_q       <= req_divisor_i;
            req_ready_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            poll_cnt    <= '0;
            if (req_divisor_i == '0) begin
              rsp_quotient_o  <= '1;
              rsp_remainder_o <= req_dividend_i;
              state           <= S_RESP;
            end else begin
              state <= S_WR_DVD;
            end
          end
        end
        // Entered on the ack (or abort) edge; rsp_valid_o rises one cycle later,
        // which stands in for the idle cycle after the final transfer.
        S_RESP: begin
          if (!rsp_valid_o) begin
            rsp_valid_o <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          if (x_err) begin
            rsp_err_o       <= 1'b1;
            rsp_quotient_o  <= '0;
            rsp_remainder_o <= '0;
            state           <= S_RESP;
          end else if (x_done) begin
            case (state)
              S_WR_DVD: begin
                state <= S_WR_DVS;
                issue <= 1'b1;
              end
              S_WR_DVS: begin
                state <= S_WR_CTRL;
                issue <= 1'b1;
              end
              S_WR_CTRL: begin
                state <= S_RD_STAT;
                issue <= 1'b1;
              end
              S_RD_STAT: begin
                if (x_rdata[STAT_DONE_BIT]) begin
                  state <= S_RD_QUO;
                  issue <= 1'b1;
                end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                  rsp_err_o       <= 1'b1;
                  rsp_quotient_o  <= '0;
                  rsp_remainder_o <= '0;
                  state           <= S_RESP;
                end else begin
                  poll_cnt <= poll_cnt + PW'(1);
                  issue    <= 1'b1;
                end
              end
              S_RD_QUO: begin
                rsp_quotient_o <= x_rdata[XLEN-1:0];
                state          <= S_RD_REM;
                issue          <= 1'b1;
              end
              S_RD_REM: begin
                rsp_remainder_o <= x_rdata[XLEN-1:0];
                state           <= S_RESP;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_div_master.sv
// tb/tb_wb_div_master.sv - self-checking bench for wb_div_master with a divider slave model
module tb_wb_div_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_dividend_i;
  logic [31:0] req_divisor_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_quotient_o;
  logic [31:0] rsp_remainder_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  wb_div_master dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_dividend_i  (req_dividend_i),
    .req_divisor_i   (req_divisor_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_quotient_o  (rsp_quotient_o),
    .rsp_remainder_o (rsp_remainder_o),
    .rsp_err_o       (rsp_err_o),
    .wbm_cyc_o       (wbm_cyc_o),
    .wbm_stb_o       (wbm_stb_o),
    .wbm_we_o        (wbm_we_o),
    .wbm_sel_o       (wbm_sel_o),
    .wbm_adr_o       (wbm_adr_o),
    .wbm_dat_o       (wbm_dat_o),
    .wbm_dat_i       (wbm_dat_i),
    .wbm_ack_i       (wbm_ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  exp_t sb[$];

  // Slave configuration, set from the stimulus process only.
  int          ws         = 0;
  int          done_after = 1;
  logic        noack_en   = 1'b0;
  logic [31:0] noack_adr  = '0;

  // Slave state and transfer log.
  int          cycle      = 0;
  int          s_wcnt     = 0;
  int          s_polls    = 0;
  int          stat_reads = 0;
  logic [31:0] s_dvd      = '0;
  logic [31:0] s_dvs      = '0;
  logic [31:0] log_adr[$];
  logic        log_we[$];
  logic [31:0] log_dat[$];

  logic [31:0] s_q;
  logic [31:0] s_r;
  logic        s_done;

  assign s_q       = (s_dvs != 0) ? s_dvd / s_dvs : 32'h0;
  assign s_r       = (s_dvs != 0) ? s_dvd % s_dvs : 32'h0;
  assign s_done    = (s_polls + 1 >= done_after);
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (s_wcnt >= ws) &&
                     !(noack_en && wbm_adr_o == noack_adr);
  assign wbm_dat_i = (wbm_adr_o == BASE + 32'h0C) ? {31'h0, s_done} :
                     (wbm_adr_o == BASE + 32'h10) ? s_q :
                     (wbm_adr_o == BASE + 32'h14) ? s_r : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cycle  <= cycle + 1;
    s_wcnt <= (wbm_stb_o && !wbm_ack_i) ? s_wcnt + 1 : 0;
    if (wbm_stb_o && wbm_ack_i) begin
      log_adr.push_back(wbm_adr_o);
      log_we.push_back(wbm_we_o);
      log_dat.push_back(wbm_dat_o);
      if (wbm_we_o) begin
        if (wbm_adr_o == BASE + 32'h00) s_dvd <= wbm_dat_o;
        if (wbm_adr_o == BASE + 32'h04) s_dvs <= wbm_dat_o;
        if (wbm_adr_o == BASE + 32'h08 && wbm_dat_o[0]) s_polls <= 0;
      end else if (wbm_adr_o == BASE + 32'h0C) begin
        stat_reads <= stat_reads + 1;
        s_polls    <= s_polls + 1;
      end
    end
  end

  // Protocol and response monitor, sampled mid-cycle.
  logic        held      = 1'b0;
  logic        after_ack = 1'b0;
  logic        prev_rv   = 1'b0;
  logic [31:0] h_adr     = '0;
  logic [31:0] h_dat     = '0;
  logic        h_we      = 1'b0;
  int          viol        = 0;
  int          run         = 0;
  int          max_run     = 0;
  int          cyc_cycles  = 0;
  int          first_valid = 0;
  int          rsp_count   = 0;
  int          hs_cycle    = 0;

  always @(negedge clk) begin
    if (wbm_stb_o && held && (wbm_adr_o != h_adr || wbm_dat_o != h_dat || wbm_we_o != h_we))
      viol <= viol + 1;
    if (wbm_stb_o && after_ack)
      viol <= viol + 1;
    held      <= wbm_stb_o && !wbm_ack_i;
    after_ack <= wbm_stb_o && wbm_ack_i;
    h_adr     <= wbm_adr_o;
    h_dat     <= wbm_dat_o;
    h_we      <= wbm_we_o;
    run       <= wbm_stb_o ? run + 1 : 0;
    if (wbm_stb_o && run + 1 > max_run) max_run <= run + 1;
    if (wbm_cyc_o) cyc_cycles <= cyc_cycles + 1;
    if (rsp_valid_o && !prev_rv) first_valid <= cycle;
    prev_rv <= rsp_valid_o;
    if (rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        check("rsp_quotient", rsp_quotient_o, sb[0].q);
        check("rsp_remainder", rsp_remainder_o, sb[0].r);
        check("rsp_err", {31'h0, rsp_err_o}, {31'h0, sb[0].err});
        void'(sb.pop_front());
      end
      rsp_count <= rsp_count + 1;
    end
  end

  task automatic do_req(input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic ee, input logic push);
    int n = 0;
    if (push) sb.push_back('{q: eq, r: er, err: ee});
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_dividend_i = dvd;
    req_divisor_i  = dvs;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("req_accept_timeout", 32'd0, 32'd1);
    hs_cycle = cycle + 1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int start = rsp_count;
    int n = 0;
    while (rsp_count == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rsp_count == start) check("rsp_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          lb;
    int          sr;
    int          cc;
    int          rc;
    int          n;
    int          hold_viol;
    logic [31:0] hq;
    logic [31:0] hr;
    logic [31:0] ea[6];
    logic        ewe[6];
    logic [31:0] ed[3];

    reset_i        = 1'b1;
    req_valid_i    = 1'b0;
    req_dividend_i = '0;
    req_divisor_i  = '0;
    rsp_ready_i    = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    check("reset_req_ready", {31'h0, req_ready_o}, 32'd1);
    check("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'd0);
    check("reset_cyc", {31'h0, wbm_cyc_o}, 32'd0);
    check("reset_stb", {31'h0, wbm_stb_o}, 32'd0);
    check("reset_sel", {28'h0, wbm_sel_o}, 32'hF);

    // Zero-wait slave, 100 / 7.
    ea  = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10, BASE + 32'h14};
    ewe = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ed  = '{32'd100, 32'd7, 32'd1};
    lb  = log_adr.size();
    do_req(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    wait_rsp(200);
    check("t1_latency", first_valid - hs_cycle, 32'd12);
    check("t1_xfer_count", log_adr.size() - lb, 32'd6);
    if (log_adr.size() - lb == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("t1_adr%0d", i), log_adr[lb + i], ea[i]);
        check($sformatf("t1_we%0d", i), {31'h0, log_we[lb + i]}, {31'h0, ewe[i]});
        if (i < 3) check($sformatf("t1_dat%0d", i), log_dat[lb + i], ed[i]);
      end
    end

    // Three wait states, done on the fifth poll.
    ws = 3;
    done_after = 5;
    sr = stat_reads;
    do_req(32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 1'b1);
    wait_rsp(500);
    check("t2_status_reads", stat_reads - sr, 32'd5);
    check("t2_protocol_viol", viol, 32'd0);
    ws = 0;
    done_after = 1;

    // Divide by zero: no bus activity.
    cc = cyc_cycles;
    do_req(32'd42, 32'd0, 32'hFFFF_FFFF, 32'd42, 1'b0, 1'b1);
    wait_rsp(50);
    check("t3_cyc_cycles", cyc_cycles - cc, 32'd0);

    // DIVISOR write never acked: abort after 64 stalled cycles, then recover.
    noack_en  = 1'b1;
    noack_adr = BASE + 32'h4;
    do_req(32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 1'b1);
    wait_rsp(300);
    check("t4_stall_length", max_run, 32'd64);
    noack_en = 1'b0;
    do_req(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
    wait_rsp(200);

    // Done never set: poll-limit abort, response held while not consumed.
    done_after  = 100000;
    rsp_ready_i = 1'b0;
    sr = stat_reads;
    do_req(32'd77, 32'd7, 32'd0, 32'd0, 1'b1, 1'b1);
    n = 0;
    while (!rsp_valid_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t5_rsp_valid_seen", {31'h0, rsp_valid_o}, 32'd1);
    check("t5_status_reads", stat_reads - sr, 32'd1024);
    hq = rsp_quotient_o;
    hr = rsp_remainder_o;
    hold_viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid_o || rsp_quotient_o != hq || rsp_remainder_o != hr || !rsp_err_o)
        hold_viol++;
    end
    check("t5_hold_stable", hold_viol, 32'd0);
    rsp_ready_i = 1'b1;
    wait_rsp(20);
    @(negedge clk);
    check("t5_valid_dropped", {31'h0, rsp_valid_o}, 32'd0);

    // Reset while polling STATUS.
    sr = stat_reads;
    do_req(32'd8, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (stat_reads - sr < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_polling_reached", (stat_reads - sr >= 3) ? 32'd1 : 32'd0, 32'd1);
    rc = rsp_count;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("t6_cyc", {31'h0, wbm_cyc_o}, 32'd0);
    check("t6_stb", {31'h0, wbm_stb_o}, 32'd0);
    check("t6_req_ready", {31'h0, req_ready_o}, 32'd1);
    check("t6_rsp_valid", {31'h0, rsp_valid_o}, 32'd0);
    repeat (20) @(negedge clk);
    check("t6_no_rsp", rsp_count - rc, 32'd0);
    done_after = 1;
    do_req(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    wait_rsp(200);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
